// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux4to1 scan sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NCH       = 4;
  localparam int SEL_W     = 2;
  localparam int DWELL_DEF = 2;

endpackage

// File: rtl/dwell_timer.sv
// Per-channel dwell timer: counts 0..DWELL-1 while enabled, last flags the final cycle.
module dwell_timer #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int W = 8;

  logic [W-1:0] dwell;

  assign last = (dwell == W'(DWELL - 1));

  // Wraps to zero on its own after the last cycle so the next channel starts cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
    end else if (clr || (en && last)) begin
      dwell <= '0;
    end else if (en) begin
      dwell <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans mux4to1 channels 0..3, samples y on each channel's last dwell cycle and
// hands the 4-bit frame downstream over valid/ready.
//
// state | meaning
// IDLE  | selects channel 0, waits for start
// SCAN  | drives current channel, samples y on last dwell cycle
// HOLD  | frame_valid high, waits for frame_ready
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = DWELL_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             y,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic [3:0]       frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [CNT_W-1:0] frame_cnt
);

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [NCH-2:0]   shadow;
  logic             last;
  logic             timer_en;
  logic             timer_clr;

  assign timer_en  = (state == SCAN);
  assign timer_clr = (state != SCAN);

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .en    (timer_en),
    .last  (last)
  );

  // sel doubles as the channel index and the registered select output.
  assign s1 = sel[1];
  assign s0 = sel[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      shadow      <= '0;
      busy        <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          sel <= '0;
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (last) begin
            if (sel != SEL_W'(NCH - 1)) begin
              shadow[sel] <= y;
              sel         <= sel + 1'b1;
            end else begin
              frame       <= {y, shadow};
              frame_valid <= 1'b1;
              sel         <= '0;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          sel <= '0;
          if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
            frame_cnt   <= frame_cnt + 1'b1;
            if (cont) begin
              state <= SCAN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          sel         <= '0;
          busy        <= 1'b0;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: instance 0 (DWELL=2, CNT_W=8), instance 1 (DWELL=1, CNT_W=2).
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [2];
  logic       cont  [2];
  logic       ready [2];
  logic       y     [2];
  logic       s1    [2];
  logic       s0    [2];
  logic       busy  [2];
  logic       fv    [2];
  logic [3:0] frame [2];
  logic [3:0] ch_in [2];
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // mux4to1 stand-in: bit i of ch_in is the channel-i input
  assign y[0] = ch_in[0][{s1[0], s0[0]}];
  assign y[1] = ch_in[1][{s1[1], s0[1]}];

  mux_scan_ctrl #(.DWELL(2), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .cont(cont[0]), .y(y[0]),
    .s1(s1[0]), .s0(s0[0]), .busy(busy[0]), .frame(frame[0]),
    .frame_valid(fv[0]), .frame_ready(ready[0]), .frame_cnt(cnt_a)
  );

  mux_scan_ctrl #(.DWELL(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .cont(cont[1]), .y(y[1]),
    .s1(s1[1]), .s0(s0[1]), .busy(busy[1]), .frame(frame[1]),
    .frame_valid(fv[1]), .frame_ready(ready[1]), .frame_cnt(cnt_b)
  );

  function automatic int dw(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int cnt_mod(input int i);
    return (i == 0) ? 256 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 scanning (t = cycles since scan start), 2 holding
  int         m_mode [2];
  int         m_t    [2];
  int         m_cnt  [2];
  logic [3:0] m_samp [2];
  logic [3:0] m_frame[2];
  logic       m_valid[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = 0; m_t[i] = 0; m_cnt[i] = 0;
        m_samp[i] = '0; m_frame[i] = '0; m_valid[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_mode[i])
          0: if (start[i]) begin m_mode[i] = 1; m_t[i] = 0; end
          1: begin
            if (m_t[i] % dw(i) == dw(i) - 1)
              m_samp[i][m_t[i] / dw(i)] = ch_in[i][m_t[i] / dw(i)];
            m_t[i]++;
            if (m_t[i] == 4 * dw(i)) begin
              m_frame[i] = m_samp[i];
              m_valid[i] = 1'b1;
              m_mode[i]  = 2;
            end
          end
          default: if (ready[i]) begin
            m_valid[i] = 1'b0;
            m_cnt[i]++;
            if (cont[i]) begin m_mode[i] = 1; m_t[i] = 0; end
            else m_mode[i] = 0;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sel%0d", i), {30'd0, s1[i], s0[i]},
            (m_mode[i] == 1) ? m_t[i] / dw(i) : 0);
        chk($sformatf("busy%0d", i), busy[i], m_mode[i] != 0);
        chk($sformatf("valid%0d", i), fv[i], m_valid[i]);
        chk($sformatf("frame%0d", i), frame[i], m_frame[i]);
        chk($sformatf("cnt%0d", i), (i == 0) ? cnt_a : cnt_b, m_cnt[i] % cnt_mod(i));
      end
    end
  end

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; cont[i] = 1'b0; ready[i] = 1'b1;
    end
    ch_in[0] = 4'b1010;
    ch_in[1] = 4'b0011;
    repeat (2) @(negedge clk);
    chk("rst_sel_a", {s1[0], s0[0]}, 0);
    chk("rst_busy_a", busy[0], 0);
    chk("rst_valid_a", fv[0], 0);
    chk("rst_frame_a", frame[0], 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single shot, static data, with a start pulse ignored mid-scan
    pulse_start(0);
    repeat (3) @(negedge clk);
    chk("sel_step_a", {s1[0], s0[0]}, 2'b01);
    pulse_start(0);
    chk("sel_ch2_a", {s1[0], s0[0]}, 2'b10);
    repeat (3) @(negedge clk);
    chk("valid_early_a", fv[0], 0);
    @(negedge clk);
    chk("valid_rise_a", fv[0], 1);
    chk("frame_1010", frame[0], 4'b1010);
    @(negedge clk);
    chk("valid_one_cycle_a", fv[0], 0);
    chk("cnt_after_one", cnt_a, 1);
    chk("idle_after_one", busy[0], 0);

    // backpressure, with a start pulse in HOLD
    ch_in[0] = 4'b0110;
    ready[0] = 1'b0;
    pulse_start(0);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", fv[0], 1);
      chk("stall_frame", frame[0], 4'b0110);
      start[0] = (k == 1);
      @(negedge clk);
    end
    start[0] = 1'b0;
    ready[0] = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", fv[0], 0);
    chk("stall_cnt", cnt_a, 2);
    chk("stall_idle", busy[0], 0);
    chk("frame_retained", frame[0], 4'b0110);

    // continuous mode, DWELL=1, then counter wrap with CNT_W=2
    cont[1] = 1'b1;
    pulse_start(1);
    for (int k = 0; k < 20 && !fv[1]; k++) @(negedge clk);
    chk("cont_first_valid", fv[1], 1);
    nvalid = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (fv[1]) nvalid++;
    end
    chk("cont_valid_count", nvalid, 3);
    chk("cont_cnt3", cnt_b, 3);
    chk("cont_frame", frame[1], 4'b0011);
    @(negedge clk);
    cont[1] = 1'b0;
    chk("cnt_wrap0", cnt_b, 0);
    chk("cont_rescan", busy[1], 1);
    repeat (6) @(negedge clk);
    chk("cnt_wrap_five", cnt_b, 1);
    chk("cont_stop_idle", busy[1], 0);

    // asynchronous reset while channel 2 is selected
    ch_in[0] = 4'b1010;
    pulse_start(0);
    repeat (4) @(negedge clk);
    chk("pre_rst_sel", {s1[0], s0[0]}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", {s1[0], s0[0]}, 0);
    chk("arst_busy", busy[0], 0);
    chk("arst_valid", fv[0], 0);
    chk("arst_frame", frame[0], 0);
    chk("arst_cnt", cnt_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
